// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use stalls, multi-cycle branch flushes and data-memory freezes.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined; otherwise they read 0.
module hazard_ctrl #(
  parameter int REG_ADDR_W     = 5,
  parameter int BRANCH_PENALTY = 1,
  parameter int MEM_TIMEOUT    = 255,
  parameter int CNT_W          = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [REG_ADDR_W-1:0] id_rs_i,
  input  logic [REG_ADDR_W-1:0] id_rt_i,
  input  logic                  id_uses_rt_i,
  input  logic                  ex_memread_i,
  input  logic [REG_ADDR_W-1:0] ex_rt_i,
  input  logic                  branch_taken_i,
  input  logic                  dmem_busy_i,
  output logic                  pc_write_o,
  output logic                  IF_ID_sel_o,
  output logic                  flush_o,
  output logic                  id_ex_bubble_o,
  output logic                  id_ex_hold_o,
  output logic [1:0]            state_o,
  output logic                  mem_timeout_o,
  output logic [CNT_W-1:0]      stall_cycles_o,
  output logic [CNT_W-1:0]      flush_cycles_o
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    BR_FLUSH = 2'd1,
    MEM_WAIT = 2'd2
  } state_e;

  localparam logic [1:0] PenaltyLeft = 2'(BRANCH_PENALTY - 1);
  localparam logic [7:0] TimeoutLast = 8'(MEM_TIMEOUT - 1);

  state_e     state_q, state_d, effState;
  logic [1:0] flushLeft_q, flushLeft_d;
  logic [7:0] waitCnt_q, waitCnt_d;
  logic       timeout_q, timeout_d;
  logic       loadUse;

  assign loadUse = ex_memread_i && (ex_rt_i != '0) &&
                   ((ex_rt_i == id_rs_i) || (id_uses_rt_i && (ex_rt_i == id_rt_i)));

  // A pending flush count survives a freeze, so it alone tells which state MEM_WAIT returns to.
  always_comb begin
    effState = state_q;
    if (state_q == MEM_WAIT) begin
      effState = (flushLeft_q != 2'd0) ? BR_FLUSH : RUN;
    end
  end

  always_comb begin
    state_d        = state_q;
    flushLeft_d    = flushLeft_q;
    pc_write_o     = 1'b0;
    IF_ID_sel_o    = 1'b0;
    flush_o        = 1'b0;
    id_ex_bubble_o = 1'b0;
    id_ex_hold_o   = 1'b0;
    if (!rst_ni) begin
      flush_o        = 1'b1;
      id_ex_bubble_o = 1'b1;
      state_d        = RUN;
      flushLeft_d    = 2'd0;
    end else if (dmem_busy_i) begin
      id_ex_hold_o = 1'b1;
      state_d      = MEM_WAIT;
    end else begin
      case (effState)
        BR_FLUSH: begin
          pc_write_o     = 1'b1;
          IF_ID_sel_o    = 1'b1;
          flush_o        = 1'b1;
          id_ex_bubble_o = 1'b1;
          flushLeft_d    = (flushLeft_q != 2'd0) ? flushLeft_q - 2'd1 : 2'd0;
          state_d        = (flushLeft_q <= 2'd1) ? RUN : BR_FLUSH;
        end
        default: begin
          state_d = RUN;
          if (branch_taken_i) begin
            pc_write_o     = 1'b1;
            IF_ID_sel_o    = 1'b1;
            flush_o        = 1'b1;
            id_ex_bubble_o = 1'b1;
            if (BRANCH_PENALTY > 1) begin
              flushLeft_d = PenaltyLeft;
              state_d     = BR_FLUSH;
            end
          end else if (loadUse) begin
            id_ex_bubble_o = 1'b1;
          end else begin
            pc_write_o  = 1'b1;
            IF_ID_sel_o = 1'b1;
          end
        end
      endcase
    end
  end

  // Watchdog counts consecutive busy cycles; the error flag is sticky until reset.
  always_comb begin
    waitCnt_d = 8'd0;
    if (dmem_busy_i) begin
      waitCnt_d = (waitCnt_q == 8'hFF) ? 8'hFF : waitCnt_q + 8'd1;
    end
    timeout_d = timeout_q | (dmem_busy_i && (waitCnt_q >= TimeoutLast));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= RUN;
      flushLeft_q <= 2'd0;
      waitCnt_q   <= 8'd0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      flushLeft_q <= flushLeft_d;
      waitCnt_q   <= waitCnt_d;
      timeout_q   <= timeout_d;
    end
  end

  assign state_o       = state_q;
  assign mem_timeout_o = timeout_q;

`ifdef HAZARD_PERF_CNT_EN
  logic             stallCycle;
  logic [CNT_W-1:0] stallCnt_q, flushCnt_q;

  assign stallCycle = dmem_busy_i || ((effState == RUN) && !branch_taken_i && loadUse);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stallCnt_q <= '0;
      flushCnt_q <= '0;
    end else begin
      if (stallCycle && (stallCnt_q != '1)) begin
        stallCnt_q <= stallCnt_q + CNT_W'(1);
      end
      if (flush_o && (flushCnt_q != '1)) begin
        flushCnt_q <= flushCnt_q + CNT_W'(1);
      end
    end
  end

  assign stall_cycles_o = stallCnt_q;
  assign flush_cycles_o = flushCnt_q;
`else
  assign stall_cycles_o = '0;
  assign flush_cycles_o = '0;
`endif

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage MIPS core.
- Drives the IF_ID register's write enable (IF_ID_sel) and flush, the PC write enable, and ID_EX bubble/hold controls.
- Resolves load-use stalls, taken-branch flushes (multi-cycle penalty) and data-memory wait freezes.
- Sits beside the forwarding unit. Combinational control outputs are derived from registered state plus current hazard inputs.

Parameters:
REG_ADDR_W, 5, register-specifier width
BRANCH_PENALTY, 1, consecutive flush cycles per taken branch (legal 1..3)
MEM_TIMEOUT, 255, consecutive dmem_busy cycles before mem_timeout sets (1..255)
CNT_W, 16, width of performance counters

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
id_rs  in  REG_ADDR_W  rs of instruction in ID
id_rt  in  REG_ADDR_W  rt of instruction in ID
id_uses_rt  in  1  ID instruction reads rt
ex_memread  in  1  EX instruction is a load
ex_rt  in  REG_ADDR_W  load destination in EX
branch_taken  in  1  branch/jump resolved taken in EX
dmem_busy  in  1  data memory not ready; pipeline must freeze
pc_write  out  1  PC register enable
IF_ID_sel  out  1  IF_ID write enable
flush  out  1  IF_ID flush (clears instruction to NOP)
id_ex_bubble  out  1  load NOP into ID_EX
id_ex_hold  out  1  ID_EX/EX_MEM hold current contents
state  out  2  0=RUN, 1=BR_FLUSH, 2=MEM_WAIT
mem_timeout  out  1  sticky memory-wait watchdog error
stall_cycles  out  CNT_W  perf counter (optional feature)
flush_cycles  out  CNT_W  perf counter (optional feature)

Behaviour:
- Reset (rst=0, async):
  - state=RUN, flush_left=0, wait_cnt=0, mem_timeout=0, counters=0.
  - Outputs forced: pc_write=0, IF_ID_sel=0, flush=1, id_ex_bubble=1, id_ex_hold=0.
- Load-use hazard (LU): ex_memread && ex_rt!=0 && (ex_rt==id_rs || (id_uses_rt && ex_rt==id_rt)).
- Per-cycle priority: dmem_busy > branch > LU > normal.
- FREEZE, any state with dmem_busy=1:
  - pc_write=0, IF_ID_sel=0, flush=0, id_ex_bubble=0, id_ex_hold=1.
  - Next state MEM_WAIT. flush_left is not decremented.
  - Return state is remembered: RUN, or BR_FLUSH when flush_left>0.
- MEM_WAIT with dmem_busy=0: outputs and next state evaluated exactly as in the remembered state, in that same cycle (zero-cycle exit).
- RUN:
  - branch_taken: pc_write=1, IF_ID_sel=1, flush=1, id_ex_bubble=1. If BRANCH_PENALTY>1, flush_left<=BRANCH_PENALTY-1 and go to BR_FLUSH; else stay in RUN.
  - Else LU: pc_write=0, IF_ID_sel=0, flush=0, id_ex_bubble=1. One bubble per cycle of hazard; stays in RUN.
  - Else normal: pc_write=1, IF_ID_sel=1, flush=0, id_ex_bubble=0, id_ex_hold=0.
- BR_FLUSH:
  - Outputs as a RUN branch cycle.
  - flush_left decrements each non-frozen cycle; go to RUN in the cycle flush_left goes 1->0.
  - branch_taken and LU are ignored in this state (EX holds a bubble).
- Branch and LU in the same cycle: branch wins; the stalled instruction is squashed.
- Watchdog:
  - wait_cnt (8 bit) increments on consecutive dmem_busy cycles and clears when dmem_busy=0.
  - When wait_cnt reaches MEM_TIMEOUT, mem_timeout<=1. It is sticky until reset; the freeze still continues.
- Reset mid-BR_FLUSH or mid-MEM_WAIT: abandons the sequence immediately; first cycle after release is RUN.
- No latency through the controller: control outputs are combinational from registered state plus current inputs, effective at the next clk edge of the controlled registers.

Optional Feature:
- HAZARD_PERF_CNT_EN defined:
  - stall_cycles increments on every LU or FREEZE cycle.
  - flush_cycles increments on every cycle with flush=1 (excluding reset).
  - Both saturate at 2^CNT_W-1 and clear on reset.
- Undefined: stall_cycles and flush_cycles are tied to 0; no counter flops. The port list is unchanged.

Test Plan:
- Reset held low 2 cycles with branch_taken=1 and dmem_busy=1 -> pc_write=0, IF_ID_sel=0, flush=1, id_ex_bubble=1, state=0, mem_timeout=0. After release with idle inputs -> pc_write=1, IF_ID_sel=1.
- ex_memread=1, ex_rt=5, id_rs=5 for 1 cycle -> pc_write=0, IF_ID_sel=0, id_ex_bubble=1. Same with ex_rt=0 -> no stall. With id_rt=5 and id_uses_rt=0 -> no stall.
- BRANCH_PENALTY=3, branch_taken=1 for 1 cycle -> flush=1 for exactly 3 cycles, state sequence 0->1->1->0. A second branch_taken during BR_FLUSH is ignored.
- Branch and LU in the same cycle -> flush=1, id_ex_bubble=1, pc_write=1. During BR_FLUSH, dmem_busy=1 for 4 cycles -> id_ex_hold=1, state=2, flush count pauses. After release, the remaining flush cycles resume.
- MEM_TIMEOUT=10: dmem_busy high for 9 cycles -> mem_timeout=0. Then high for 10 consecutive cycles -> mem_timeout=1, staying set after dmem_busy drops until rst=0.
- With HAZARD_PERF_CNT_EN: 2 LU cycles + 3 freeze cycles + 1 branch (penalty 1) -> stall_cycles=5, flush_cycles=1. Without the macro -> both read 0.
